net_tx_sched: RTL and testbench
===============================

// Module: net_tx_sched
// PURPOSE
//  Frame-level round-robin scheduler sharing the single network TX AXI-stream (m_net_axis_*) between
//  NUM_REQ requesters. Each requester posts a frame descriptor (start pulse + byte length), then streams
//  data beats. The block grants one frame at a time and passes the winner's beats through to the network
//  port. It generates tkeep/tlast from the descriptor length and reports per-requester completion.
// PARAMETERS
//  NUM_REQ     2                 number of requesters (2..8)
//  DATA_WIDTH  512               data bus width, bits
//  KEEP_WIDTH  DATA_WIDTH/8      bytes per beat
//  LEN_WIDTH   20                frame length field width, bytes
//  USER_WIDTH  8                 tuser width; carries granted requester index
// PORTS
//  clk               in   1                    single clock domain
//  rst_n             in   1                    asynchronous, active-low reset
//  req_start         in   NUM_REQ              per-requester 1-cycle descriptor pulse
//  req_len           in   NUM_REQ*LEN_WIDTH    frame length in bytes; slice i valid with req_start[i]
//  s_tdata           in   NUM_REQ*DATA_WIDTH   per-requester beat data
//  s_tvalid          in   NUM_REQ              per-requester beat valid
//  s_tready          out  NUM_REQ              per-requester beat ready
//  m_net_axis_tdata  out  DATA_WIDTH           network TX data
//  m_net_axis_tkeep  out  KEEP_WIDTH           byte enables, LSB-first
//  m_net_axis_tlast  out  1                    last beat of frame
//  m_net_axis_tuser  out  USER_WIDTH           granted requester index, zero-extended
//  m_net_axis_tvalid out  1                    network TX valid
//  m_net_axis_tready in   1                    network TX ready
//  req_pending       out  NUM_REQ              descriptor latched, not yet completed
//  req_done          out  NUM_REQ              1-cycle pulse when a frame completes
//  req_drop          out  NUM_REQ              1-cycle pulse: start ignored because requester was already pending
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, last_grant=NUM_REQ-1. All outputs 0: m_*, s_tready,
//   pending, done, drop.
//  Descriptor capture: req_start[i] & !pending[i] -> pending[i]=1 next cycle; len_q[i]=req_len[i].
//   req_start[i] & pending[i] -> ignored; req_drop[i]=1 next cycle.
//  FSM IDLE:
//   - If any pending: grant = first pending index after last_grant, wrapping; rem = len_q[grant]. Go to XFER.
//   - A start arriving in cycle t can be granted at t+1 and put its first beat out at t+2.
//  FSM XFER:
//   - Pure combinational pass-through: m_tvalid=s_tvalid[grant]; m_tdata=s_tdata[grant];
//     s_tready[grant]=m_tready; other s_tready=0.
//   - tkeep = (rem>=KEEP_WIDTH) ? all ones : (1<<rem)-1.
//   - tlast = (rem<=KEEP_WIDTH).
//   - On each accepted beat (m_tvalid & m_tready): rem -= KEEP_WIDTH, saturating at 0.
//   - When the tlast beat is accepted: pending[grant]=0; req_done[grant]=1 next cycle; last_grant=grant;
//     go to IDLE. IDLE therefore always inserts one bubble between frames.
//  Beat count per frame = ceil(len/KEEP_WIDTH).
//  len=0: granted, no beats, done pulse. IDLE->XFER->IDLE with s_tready and m_tvalid held 0.
//  A start for a pending requester, including during its own XFER, never disturbs the frame in flight.
//  Outside XFER: m_tvalid=0, all s_tready=0, tkeep/tlast/tdata=0.
//  m_tuser is held at the grant index throughout XFER.
//  Reset mid-frame aborts immediately: no tlast, no done pulse; all pending cleared.
// TESTING
//  1. Single req0 with len=130, KEEP_WIDTH=64, tready=1 -> 3 beats; tkeep all-ones, all-ones, 0x3;
//     tlast on beat 3; req_done[0] pulses 1 cycle after beat 3.
//  2. req0 and req1 start in the same cycle, len=64 each -> req0 granted first, then req1 after a 1-cycle
//     bubble; tuser 0 then 1.
//  3. Backpressure: len=192, tready toggles 1,0,1,0... -> exactly 3 accepted beats; tdata/tkeep stable
//     while stalled.
//  4. req1 restarts while pending -> req_drop[1] pulses; the original len is used unchanged.
//  5. len=0 -> no m_tvalid; req_done pulses 2 cycles after the start pulse.
//  6. rst_n low mid-frame -> outputs 0 asynchronously; after release, a new len=64 frame completes normally.

Source files
------------

// File: rtl/net_tx_sched_if.sv
// Network TX AXI-stream bundle carried out of net_tx_sched.
//
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both high. A master holding tvalid high keeps tdata/tkeep/tlast/tuser
// stable until that transfer happens. tready may change freely.
//
// Signals: tdata (beat payload), tkeep (byte enables, LSB-first),
//          tlast (final beat of frame), tuser (granted requester index),
//          tvalid (master has a beat), tready (slave can take a beat).
interface net_tx_sched_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/net_tx_sched.sv
// Frame-level round-robin scheduler sharing one network TX stream between
// NUM_REQ requesters. Each requester posts a descriptor (req_start pulse +
// byte length), then streams beats on its s_t* lane. One frame is granted
// at a time; its beats pass straight through to m_net_axis with tkeep/tlast
// generated from the descriptor length.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req_start/len   per-requester descriptor pulse and byte length
//   s_tdata/tvalid  per-requester beat lanes, s_tready back-pressure
//   m_net_axis      network TX stream (master side of net_tx_sched_if)
//   req_pending     descriptor latched, frame not yet completed
//   req_done        1-cycle pulse after a frame completes
//   req_drop        1-cycle pulse after a start hit an already-pending requester
//   dbg_state       current FSM state (0 = IDLE, 1 = XFER)
module net_tx_sched #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 20,
  parameter int USER_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_start,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  output logic [NUM_REQ-1:0]            s_tready,
  net_tx_sched_if.master                m_net_axis,
  output logic [NUM_REQ-1:0]            req_pending,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_drop,
  output logic                          dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LEN_WIDTH-1:0] KEEP_LEN = LEN_WIDTH'(KEEP_WIDTH);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   drop_q, drop_d;
  logic [LEN_WIDTH-1:0] len_q [NUM_REQ];
  logic [LEN_WIDTH-1:0] len_d [NUM_REQ];

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  beat_phase;
  logic                  tlast_c;
  logic [KEEP_WIDTH-1:0] tkeep_c;
  logic                  beat_acc;

  // A frame in XFER with rem_q == 0 can only be a zero-length frame: a
  // non-empty frame leaves XFER on the same edge its rem reaches zero.
  assign beat_phase = (state_q == XFER) && (rem_q != '0);
  assign tlast_c    = beat_phase && (rem_q <= KEEP_LEN);
  assign beat_acc   = m_net_axis.tvalid && m_net_axis.tready;

  always_comb begin
    tkeep_c = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      tkeep_c[b] = beat_phase && (LEN_WIDTH'(b) < rem_q);
    end
  end

  // Pass-through of the granted lane; everything reads zero outside XFER.
  always_comb begin
    s_tready          = '0;
    m_net_axis.tvalid = beat_phase && s_tvalid[grant_q];
    m_net_axis.tdata  = '0;
    m_net_axis.tkeep  = tkeep_c;
    m_net_axis.tlast  = tlast_c;
    m_net_axis.tuser  = '0;
    if (state_q == XFER) begin
      m_net_axis.tdata = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      m_net_axis.tuser = USER_WIDTH'(grant_q);
    end
    if (beat_phase) begin
      s_tready[grant_q] = m_net_axis.tready;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rem_d        = rem_q;
    pending_d    = pending_q;
    done_d       = '0;
    drop_d       = '0;
    len_d        = len_q;
    sel_found    = 1'b0;
    sel_idx      = '0;

    // Round-robin search starting just after the last completed grant.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && pending_q[(int'(last_grant_q) + k) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end

    // Descriptor capture; a start for a pending requester never touches len.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_start[i]) begin
        if (pending_q[i]) begin
          drop_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          len_d[i]     = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          rem_d   = len_q[sel_idx];
          state_d = XFER;
          // Zero-length frames complete at grant time so the done pulse
          // lands in the XFER cycle; XFER then just returns to IDLE.
          if (len_q[sel_idx] == '0) begin
            pending_d[sel_idx] = 1'b0;
            done_d[sel_idx]    = 1'b1;
            last_grant_d       = sel_idx;
          end
        end
      end
      XFER: begin
        if (!beat_phase) begin
          state_d = IDLE;
        end else if (beat_acc) begin
          rem_d = (rem_q > KEEP_LEN) ? (rem_q - KEEP_LEN) : '0;
          if (tlast_c) begin
            pending_d[grant_q] = 1'b0;
            done_d[grant_q]    = 1'b1;
            last_grant_d       = grant_q;
            state_d            = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rem_q        <= '0;
      pending_q    <= '0;
      done_q       <= '0;
      drop_q       <= '0;
      for (int i = 0; i < NUM_REQ; i++) len_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rem_q        <= rem_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
      for (int i = 0; i < NUM_REQ; i++) len_q[i] <= len_d[i];
    end
  end

  assign req_pending = pending_q;
  assign req_done    = done_q;
  assign req_drop    = drop_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_net_tx_sched.sv
module tb_net_tx_sched;
  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 512;
  localparam int KEEP_WIDTH = 64;
  localparam int LEN_WIDTH  = 20;
  localparam int USER_WIDTH = 8;
  localparam logic [KEEP_WIDTH-1:0] KEEP_ONES = '1;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_start;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]            s_tvalid;
  logic [NUM_REQ-1:0]            s_tready;
  logic [NUM_REQ-1:0]            req_pending;
  logic [NUM_REQ-1:0]            req_done;
  logic [NUM_REQ-1:0]            req_drop;
  logic                          dbg_state;

  net_tx_sched_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
                    .USER_WIDTH(USER_WIDTH)) m_if ();

  net_tx_sched #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
                 .LEN_WIDTH(LEN_WIDTH), .USER_WIDTH(USER_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_start  (req_start),
    .req_len    (req_len),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_net_axis (m_if),
    .req_pending(req_pending),
    .req_done   (req_done),
    .req_drop   (req_drop),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int beat_cnt [NUM_REQ];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] data_of(input int req, input int n);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    d[63:56] = 8'(req);
    d[55:0]  = 56'(n);
    d[511:504] = 8'hA5;
    return d;
  endfunction

  // Driver tasks: inputs change at the falling edge, outputs sampled 1ns later.
  task automatic settle();
    for (int i = 0; i < NUM_REQ; i++) s_tdata[i*DATA_WIDTH +: DATA_WIDTH] = data_of(i, beat_cnt[i]);
    #1;
  endtask

  task automatic next_cyc();
    for (int i = 0; i < NUM_REQ; i++) if (s_tready[i] && s_tvalid[i]) beat_cnt[i]++;
    @(negedge clk);
    req_start = '0;
  endtask

  task automatic set_len(input int req, input int len);
    req_len[req*LEN_WIDTH +: LEN_WIDTH] = LEN_WIDTH'(len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_start = '0;
    req_len = '0;
    s_tvalid = '1;
    m_if.tready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) beat_cnt[i] = 0;
    repeat (2) @(negedge clk);
    settle();
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_tkeep_tlast", {m_if.tkeep, m_if.tlast}, 0);
    check("rst_tuser", m_if.tuser, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_flags", {req_pending, req_done, req_drop}, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int beats, done_seen;
  logic [DATA_WIDTH-1:0] prev_data;
  logic [KEEP_WIDTH-1:0] prev_keep;
  logic prev_stall;

  initial begin
    rst_n = 1'b0;
    req_start = '0;
    req_len = '0;
    s_tdata = '0;
    s_tvalid = '0;
    m_if.tready = 1'b0;

    // 1: single req0, len=130 -> 3 beats, keep ones/ones/0x3
    do_reset();
    req_start = 2'b01; set_len(0, 130); settle();
    check("t1_c0_pending", req_pending, 2'b00);
    next_cyc(); settle();
    check("t1_c1_pending", req_pending, 2'b01);
    check("t1_c1_tvalid", m_if.tvalid, 0);
    next_cyc(); settle();
    check("t1_b1_tvalid", m_if.tvalid, 1);
    check("t1_b1_tkeep", m_if.tkeep, KEEP_ONES);
    check("t1_b1_tlast", m_if.tlast, 0);
    check("t1_b1_tuser", m_if.tuser, 0);
    check("t1_b1_tdata", m_if.tdata, data_of(0, 0));
    check("t1_b1_s_tready", s_tready, 2'b01);
    next_cyc(); settle();
    check("t1_b2_tkeep", m_if.tkeep, KEEP_ONES);
    check("t1_b2_tlast", m_if.tlast, 0);
    check("t1_b2_tdata", m_if.tdata, data_of(0, 1));
    next_cyc(); settle();
    check("t1_b3_tkeep", m_if.tkeep, 64'h3);
    check("t1_b3_tlast", m_if.tlast, 1);
    check("t1_b3_done", req_done, 2'b00);
    next_cyc(); settle();
    check("t1_done", req_done, 2'b01);
    check("t1_pending_clr", req_pending, 2'b00);
    check("t1_idle_tvalid", m_if.tvalid, 0);
    next_cyc(); settle();
    check("t1_done_1cyc", req_done, 2'b00);

    // 2: simultaneous starts, len=64 each -> req0 then bubble then req1
    do_reset();
    req_start = 2'b11; set_len(0, 64); set_len(1, 64); settle();
    next_cyc(); settle();
    check("t2_pending", req_pending, 2'b11);
    next_cyc(); settle();
    check("t2_f0_tvalid", m_if.tvalid, 1);
    check("t2_f0_tuser", m_if.tuser, 0);
    check("t2_f0_tlast", m_if.tlast, 1);
    check("t2_f0_tkeep", m_if.tkeep, KEEP_ONES);
    check("t2_f0_s_tready", s_tready, 2'b01);
    next_cyc(); settle();
    check("t2_bubble_tvalid", m_if.tvalid, 0);
    check("t2_done0", req_done, 2'b01);
    check("t2_pending_mid", req_pending, 2'b10);
    next_cyc(); settle();
    check("t2_f1_tvalid", m_if.tvalid, 1);
    check("t2_f1_tuser", m_if.tuser, 1);
    check("t2_f1_s_tready", s_tready, 2'b10);
    check("t2_f1_tdata", m_if.tdata, data_of(1, 0));
    next_cyc(); settle();
    check("t2_done1", req_done, 2'b10);
    check("t2_end_tvalid", m_if.tvalid, 0);

    // 3: backpressure, len=192, tready toggling 1,0,1,0...
    do_reset();
    req_start = 2'b01; set_len(0, 192); settle();
    next_cyc(); settle();
    next_cyc();
    beats = 0; done_seen = 0; prev_stall = 1'b0; prev_data = '0; prev_keep = '0;
    for (int k = 0; k < 12; k++) begin
      m_if.tready = (k % 2 == 0);
      settle();
      if (m_if.tvalid && prev_stall) begin
        check("t3_stall_tdata", m_if.tdata, prev_data);
        check("t3_stall_tkeep", m_if.tkeep, prev_keep);
      end
      if (m_if.tvalid && m_if.tready) begin
        check("t3_beat_tdata", m_if.tdata, data_of(0, beats));
        check("t3_beat_tkeep", m_if.tkeep, KEEP_ONES);
        check("t3_beat_tlast", m_if.tlast, beats == 2);
        beats++;
      end
      if (req_done[0]) done_seen++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data = m_if.tdata;
      prev_keep = m_if.tkeep;
      next_cyc();
    end
    m_if.tready = 1'b1;
    check("t3_beats", beats, 3);
    check("t3_done_count", done_seen, 1);

    // 4: req1 restart while pending -> drop, original len=128 kept
    do_reset();
    req_start = 2'b10; set_len(1, 128); settle();
    next_cyc();
    req_start = 2'b10; set_len(1, 5); settle();
    check("t4_pending", req_pending, 2'b10);
    next_cyc();
    req_start = 2'b10; set_len(1, 1); settle();
    check("t4_drop", req_drop, 2'b10);
    check("t4_b1_tuser", m_if.tuser, 1);
    check("t4_b1_tkeep", m_if.tkeep, KEEP_ONES);
    check("t4_b1_tlast", m_if.tlast, 0);
    next_cyc(); settle();
    check("t4_drop_xfer", req_drop, 2'b10);
    check("t4_b2_tkeep", m_if.tkeep, KEEP_ONES);
    check("t4_b2_tlast", m_if.tlast, 1);
    next_cyc(); settle();
    check("t4_done", req_done, 2'b10);
    check("t4_drop_clr", req_drop, 2'b00);

    // 5: len=0 -> no beats, done 2 cycles after start
    do_reset();
    req_start = 2'b01; set_len(0, 0); settle();
    check("t5_c0_tvalid", m_if.tvalid, 0);
    next_cyc(); settle();
    check("t5_c1_tvalid", m_if.tvalid, 0);
    check("t5_c1_done", req_done, 2'b00);
    next_cyc(); settle();
    check("t5_c2_done", req_done, 2'b01);
    check("t5_c2_tvalid", m_if.tvalid, 0);
    check("t5_c2_s_tready", s_tready, 2'b00);
    check("t5_c2_state", dbg_state, 1);
    next_cyc(); settle();
    check("t5_c3_done", req_done, 2'b00);
    check("t5_c3_state", dbg_state, 0);
    check("t5_c3_pending", req_pending, 2'b00);

    // 6: reset mid-frame aborts asynchronously, then a fresh frame completes
    do_reset();
    req_start = 2'b01; set_len(0, 192); settle();
    next_cyc(); settle();
    next_cyc(); settle();
    check("t6_pre_tvalid", m_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", m_if.tvalid, 0);
    check("t6_async_s_tready", s_tready, 2'b00);
    check("t6_async_pending", req_pending, 2'b00);
    check("t6_async_tkeep", m_if.tkeep, 0);
    @(negedge clk); #1;
    check("t6_no_done", req_done, 2'b00);
    do_reset();
    req_start = 2'b01; set_len(0, 64); settle();
    next_cyc(); settle();
    next_cyc(); settle();
    check("t6_new_tvalid", m_if.tvalid, 1);
    check("t6_new_tlast", m_if.tlast, 1);
    check("t6_new_tkeep", m_if.tkeep, KEEP_ONES);
    next_cyc(); settle();
    check("t6_new_done", req_done, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
